// File: rtl/ram256x1_arbiter.sv
`default_nettype none
// ==========================================================================
// ram256x1_arbiter : round-robin sharing of a 256x1 single-port RAM between
//   requesters A and B, plus a clear engine that fills all 256 locations.
//   Optional macro RAM256_ARB_FIXED_PRIO_EN: fixed priority, A beats B.
// Revision 1.0
// ==========================================================================
module ram256x1_arbiter #(
  parameter logic RR_INIT      = 1'b0,
  parameter logic CLR_ON_RESET = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A_REQ,
  input  logic       A_WE,
  input  logic [7:0] A_ADDR,
  input  logic       A_D,
  output logic       A_GNT,
  output logic       A_RVALID,
  output logic       A_RDATA,
  input  logic       B_REQ,
  input  logic       B_WE,
  input  logic [7:0] B_ADDR,
  input  logic       B_D,
  output logic       B_GNT,
  output logic       B_RVALID,
  output logic       B_RDATA,
  input  logic       CLR_REQ,
  input  logic       CLR_VAL,
  output logic       BUSY,
  output logic       RAM_WE,
  output logic [7:0] RAM_A,
  output logic       RAM_D,
  input  logic       RAM_O
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clr_val_q, clr_val_d;
  logic       auto_q, auto_d;
  logic [7:0] ram_a_q, ram_a_d;
  logic       ram_d_q, ram_d_d;
  logic       a_rvalid_q, a_rvalid_d, a_rdata_q, a_rdata_d;
  logic       b_rvalid_q, b_rvalid_d, b_rdata_q, b_rdata_d;
  logic       a_gnt, b_gnt, ram_we;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    clr_val_d  = clr_val_q;
    auto_d     = 1'b0;
    ram_a_d    = ram_a_q;
    ram_d_d    = ram_d_q;
    ram_we     = 1'b0;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    a_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rvalid_d = 1'b0;
    b_rdata_d  = b_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // A clear request (or the post-reset auto clear) beats any pending access
        if (CLR_REQ || auto_q) begin
          state_d   = ST_CLEAR;
          clr_val_d = CLR_VAL;
          cnt_d     = 8'h00;
        end else begin
`ifdef RAM256_ARB_FIXED_PRIO_EN
          a_gnt = A_REQ;
          b_gnt = B_REQ & ~A_REQ;
`else
          a_gnt = A_REQ & (~B_REQ | ~ptr_q);
          b_gnt = B_REQ & (~A_REQ | ptr_q);
          if (a_gnt)      ptr_d = 1'b1;
          else if (b_gnt) ptr_d = 1'b0;
`endif
          if (a_gnt) begin
            ram_we     = A_WE;
            ram_a_d    = A_ADDR;
            ram_d_d    = A_D;
            a_rvalid_d = ~A_WE;
            if (!A_WE) a_rdata_d = RAM_O;
          end else if (b_gnt) begin
            ram_we     = B_WE;
            ram_a_d    = B_ADDR;
            ram_d_d    = B_D;
            b_rvalid_d = ~B_WE;
            if (!B_WE) b_rdata_d = RAM_O;
          end
        end
      end
      ST_CLEAR: begin
        ram_we  = 1'b1;
        ram_a_d = cnt_q;
        ram_d_d = clr_val_q;
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= RR_INIT;
      cnt_q      <= 8'h00;
      clr_val_q  <= 1'b0;
      auto_q     <= CLR_ON_RESET;
      ram_a_q    <= 8'h00;
      ram_d_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      a_rdata_q  <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      clr_val_q  <= clr_val_d;
      auto_q     <= auto_d;
      ram_a_q    <= ram_a_d;
      ram_d_q    <= ram_d_d;
      a_rvalid_q <= a_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rvalid_q <= b_rvalid_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Reset forces the combinational RAM/grant outputs to their idle values at once
  assign A_GNT    = a_gnt & ~RST;
  assign B_GNT    = b_gnt & ~RST;
  assign RAM_WE   = ram_we & ~RST;
  assign RAM_A    = RST ? 8'h00 : ram_a_d;
  assign RAM_D    = RST ? 1'b0 : ram_d_d;
  assign BUSY     = (state_q == ST_CLEAR);
  assign A_RVALID = a_rvalid_q;
  assign A_RDATA  = a_rdata_q;
  assign B_RVALID = b_rvalid_q;
  assign B_RDATA  = b_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram256x1_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_ram256x1_arbiter : directed bench with a RAM instance and a cycle model.
// Revision 1.0
// ==========================================================================
module tb_ram256x1_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       A_REQ = 0, A_WE = 0, A_D = 0;
  logic [7:0] A_ADDR = 0;
  logic       B_REQ = 0, B_WE = 0, B_D = 0;
  logic [7:0] B_ADDR = 0;
  logic       CLR_REQ = 0, CLR_VAL = 0;
  logic       A_GNT, A_RVALID, A_RDATA, B_GNT, B_RVALID, B_RDATA;
  logic       BUSY, RAM_WE, RAM_D, RAM_O;
  logic [7:0] RAM_A;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ram256x1_arbiter #(.RR_INIT(1'b0), .CLR_ON_RESET(1'b0)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_D(A_D),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_D(B_D),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .CLR_REQ(CLR_REQ), .CLR_VAL(CLR_VAL), .BUSY(BUSY),
    .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_O(RAM_O)
  );

  // The RAM itself: synchronous write on CLK, asynchronous read
  logic mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 1'b0;
  always @(posedge CLK) if (RAM_WE) mem[RAM_A] <= RAM_D;
  assign RAM_O = mem[RAM_A];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: memory contents, clear progress as a plain count,
  // whose turn it is, and the read result promised for the next cycle.
  bit       m_mem [256];
  bit       m_busy, m_val, m_ptr;
  int       m_cnt;
  bit [7:0] m_last_a;
  bit       m_rva, m_rda, m_rvb, m_rdb;
  bit       eg_a, eg_b, ewe, ed, nrva, nrvb;
  bit [7:0] ea;

  initial for (int i = 0; i < 256; i++) m_mem[i] = 1'b0;

  always @(negedge CLK) begin
    if (RST) begin
      m_busy = 0; m_cnt = 0; m_ptr = 0; m_last_a = 0;
      m_rva = 0; m_rda = 0; m_rvb = 0; m_rdb = 0;
      chk("model_rst_gnt", 32'({A_GNT, B_GNT}), 32'd0);
      chk("model_rst_rv", 32'({A_RVALID, B_RVALID, A_RDATA, B_RDATA}), 32'd0);
      chk("model_rst_ram", 32'({BUSY, RAM_WE, RAM_A}), 32'd0);
    end else begin
      chk("model_A_RVALID", 32'(A_RVALID), 32'(m_rva));
      chk("model_A_RDATA", 32'(A_RDATA), 32'(m_rda));
      chk("model_B_RVALID", 32'(B_RVALID), 32'(m_rvb));
      chk("model_B_RDATA", 32'(B_RDATA), 32'(m_rdb));
      chk("model_BUSY", 32'(BUSY), 32'(m_busy));
      eg_a = 0; eg_b = 0; ewe = 0; ed = 0; ea = m_last_a; nrva = 0; nrvb = 0;
      if (m_busy) begin
        ewe = 1; ea = m_cnt[7:0]; ed = m_val;
        m_mem[ea] = m_val;
        m_cnt++;
        if (m_cnt == 256) begin m_busy = 0; m_cnt = 0; end
      end else if (CLR_REQ) begin
        m_busy = 1; m_val = CLR_VAL; m_cnt = 0;
      end else begin
        if (A_REQ && B_REQ) begin
`ifdef RAM256_ARB_FIXED_PRIO_EN
          eg_a = 1;
`else
          eg_a = !m_ptr; eg_b = m_ptr;
`endif
        end else begin
          eg_a = A_REQ; eg_b = B_REQ;
        end
        if (eg_a) begin
          ea = A_ADDR; ewe = A_WE; ed = A_D; m_ptr = 1;
          if (A_WE) m_mem[ea] = A_D;
          else begin nrva = 1; m_rda = m_mem[ea]; end
        end
        if (eg_b) begin
          ea = B_ADDR; ewe = B_WE; ed = B_D; m_ptr = 0;
          if (B_WE) m_mem[ea] = B_D;
          else begin nrvb = 1; m_rdb = m_mem[ea]; end
        end
      end
      chk("model_A_GNT", 32'(A_GNT), 32'(eg_a));
      chk("model_B_GNT", 32'(B_GNT), 32'(eg_b));
      chk("model_RAM_WE", 32'(RAM_WE), 32'(ewe));
      chk("model_RAM_A", 32'(RAM_A), 32'(ea));
      if (ewe) chk("model_RAM_D", 32'(RAM_D), 32'(ed));
      m_last_a = ea; m_rva = nrva; m_rvb = nrvb;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    A_REQ = 1; #1;
    chk("rst_A_GNT", 32'(A_GNT), 32'd0);
    chk("rst_BUSY", 32'(BUSY), 32'd0);
    chk("rst_RAM_WE", 32'(RAM_WE), 32'd0);
    chk("rst_RAM_A", 32'(RAM_A), 32'd0);
    chk("rst_RVALID", 32'({A_RVALID, B_RVALID, A_RDATA, B_RDATA}), 32'd0);
    A_REQ = 0; RST = 0;

    // Contention: A,B,A,B with addresses 0x00 / 0xFF
    A_REQ = 1; B_REQ = 1; A_ADDR = 8'h00; B_ADDR = 8'hFF; #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_A_GNT", 32'(A_GNT), 32'(i % 2 == 0));
      chk("rr_B_GNT", 32'(B_GNT), 32'(i % 2 == 1));
      chk("rr_RAM_A", 32'(RAM_A), (i % 2 == 0) ? 32'h00 : 32'hFF);
      chk("rr_one_hot", 32'(A_GNT & B_GNT), 32'd0);
      tick();
    end
    A_REQ = 0; B_REQ = 0;

    // A writes 1 to 0x3C then reads it back
    A_REQ = 1; A_WE = 1; A_ADDR = 8'h3C; A_D = 1; #1;
    chk("wr_A_GNT", 32'(A_GNT), 32'd1);
    chk("wr_RAM_WE", 32'(RAM_WE), 32'd1);
    tick(); A_WE = 0; #1;
    chk("rd_A_GNT", 32'(A_GNT), 32'd1);
    chk("rd_RAM_WE", 32'(RAM_WE), 32'd0);
    chk("rd_A_RVALID_early", 32'(A_RVALID), 32'd0);
    tick(); A_REQ = 0; #1;
    chk("rd_A_RVALID", 32'(A_RVALID), 32'd1);
    chk("rd_A_RDATA", 32'(A_RDATA), 32'd1);
    chk("rd_B_quiet", 32'({B_GNT, B_RVALID, B_RDATA}), 32'd0);
    tick();
    chk("rd_A_RVALID_pulse", 32'(A_RVALID), 32'd0);
    chk("rd_A_RDATA_hold", 32'(A_RDATA), 32'd1);

    // Clear to 1 with a simultaneous A read of 0xA5
    CLR_REQ = 1; CLR_VAL = 1; A_REQ = 1; A_WE = 0; A_ADDR = 8'hA5; #1;
    chk("clr_start_A_GNT", 32'(A_GNT), 32'd0);
    chk("clr_start_BUSY", 32'(BUSY), 32'd0);
    tick(); CLR_REQ = 0; #1;
    n = 0;
    while (BUSY === 1'b1 && n < 300) begin
      chk("clr_RAM_A", 32'(RAM_A), 32'(n[7:0]));
      chk("clr_A_GNT", 32'(A_GNT), 32'd0);
      n++;
      tick();
    end
    chk("clr_len", n, 256);
    chk("clr_after_A_GNT", 32'(A_GNT), 32'd1);
    chk("clr_after_RAM_A", 32'(RAM_A), 32'hA5);
    tick(); A_REQ = 0; #1;
    chk("clr_rd_RVALID", 32'(A_RVALID), 32'd1);
    chk("clr_rd_RDATA", 32'(A_RDATA), 32'd1);

    // B writes 0 to 0xFF then reads it on the very next cycle
    B_REQ = 1; B_WE = 1; B_ADDR = 8'hFF; B_D = 0; #1;
    chk("bwr_B_GNT", 32'(B_GNT), 32'd1);
    tick(); B_WE = 0; #1;
    chk("brd_B_GNT", 32'(B_GNT), 32'd1);
    tick(); B_REQ = 0; #1;
    chk("brd_B_RVALID", 32'(B_RVALID), 32'd1);
    chk("brd_B_RDATA", 32'(B_RDATA), 32'd0);

    // Clear to 0; a second CLR_REQ mid-clear must be ignored
    CLR_REQ = 1; CLR_VAL = 0; #1;
    tick(); CLR_REQ = 0; CLR_VAL = 1; #1;
    n = 0;
    while (BUSY === 1'b1 && n < 300) begin
      chk("clr0_RAM_A", 32'(RAM_A), 32'(n[7:0]));
      chk("clr0_RAM_D", 32'(RAM_D), 32'd0);
      n++;
      CLR_REQ = (n == 50);
      tick();
    end
    CLR_REQ = 0; #1;
    chk("clr0_len", n, 256);
    chk("clr0_idle_BUSY", 32'(BUSY), 32'd0);
    chk("clr0_hold_RAM_A", 32'(RAM_A), 32'hFF);
    A_REQ = 1; A_ADDR = 8'h3C; #1;
    chk("clr0_rd_A_GNT", 32'(A_GNT), 32'd1);
    tick(); A_REQ = 0; #1;
    chk("clr0_rd_RDATA", 32'(A_RDATA), 32'd0);

    // Reset at clear cycle 100, then restart the clear
    CLR_REQ = 1; CLR_VAL = 1; #1;
    tick(); CLR_REQ = 0; A_REQ = 1; A_ADDR = 8'h10; #1;
    repeat (100) tick();
    chk("mid_RAM_A", 32'(RAM_A), 32'd100);
    RST = 1; #1;
    chk("mid_rst_BUSY", 32'(BUSY), 32'd0);
    chk("mid_rst_GNT", 32'({A_GNT, B_GNT}), 32'd0);
    chk("mid_rst_RVALID", 32'({A_RVALID, B_RVALID}), 32'd0);
    chk("mid_rst_RAM_WE", 32'(RAM_WE), 32'd0);
    tick(); RST = 0; A_REQ = 0; CLR_REQ = 1; #1;
    tick(); CLR_REQ = 0; #1;
    chk("restart_BUSY", 32'(BUSY), 32'd1);
    chk("restart_RAM_A", 32'(RAM_A), 32'd0);
    n = 0;
    while (BUSY === 1'b1 && n < 300) begin n++; tick(); end
    chk("restart_len", n, 256);

    // Reset while a read response is pending
    A_REQ = 1; A_WE = 0; A_ADDR = 8'h3C; #1;
    chk("rstrd_A_GNT", 32'(A_GNT), 32'd1);
    tick(); A_REQ = 0; RST = 1; #1;
    chk("rstrd_RVALID", 32'(A_RVALID), 32'd0);
    chk("rstrd_RDATA", 32'(A_RDATA), 32'd0);
    tick(); RST = 0; #1;

`ifdef RAM256_ARB_FIXED_PRIO_EN
    A_REQ = 1; B_REQ = 1; A_ADDR = 8'h01; B_ADDR = 8'h02; #1;
    for (int i = 0; i < 3; i++) begin
      chk("fix_A_GNT", 32'(A_GNT), 32'd1);
      chk("fix_B_GNT", 32'(B_GNT), 32'd0);
      tick();
    end
    A_REQ = 0; #1;
    chk("fix_B_after", 32'(B_GNT), 32'd1);
    tick(); B_REQ = 0; #1;
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram256x1_arbiter.md
Name: ram256x1_arbiter

Overview:
- Shares one 256x1 single-port distributed select-RAM between two requesters, A and B, using round-robin arbitration.
- Contains a clear engine that writes one value to all 256 locations.
- Sits between the requester logic and the RAM instance. It drives the RAM's write enable, address and data in, and samples the RAM's asynchronous data out.
- RAM write clock is CLK, non-inverted.

Parameters:
- RR_INIT, 1'b0, requester that holds priority after reset (0 = A, 1 = B).
- CLR_ON_RESET, 1'b0, when 1 a clear sequence starts automatically on the first clock after reset deasserts.

Ports:
- CLK  input  1  clock; the only clock, also drives the RAM write clock.
- RST  input  1  reset, asynchronous, active-high.
- A_REQ  input  1  requester A access request; held until A_GNT.
- A_WE  input  1  requester A: 1 = write, 0 = read.
- A_ADDR  input  8  requester A address.
- A_D  input  1  requester A write data.
- A_GNT  output  1  requester A granted this cycle (combinational).
- A_RVALID  output  1  requester A read data valid (registered).
- A_RDATA  output  1  requester A read data.
- B_REQ, B_WE, B_ADDR, B_D, B_GNT, B_RVALID, B_RDATA: same as the A ports, for requester B.
- CLR_REQ  input  1  start-clear pulse.
- CLR_VAL  input  1  value written by the clear; sampled on the start cycle.
- BUSY  output  1  clear in progress.
- RAM_WE  output  1  to RAM write enable.
- RAM_A  output  8  to RAM address.
- RAM_D  output  1  to RAM data in.
- RAM_O  input  1  from RAM asynchronous data out.

Behaviour:
- Reset values:
  - A_GNT=B_GNT=0, A_RVALID=B_RVALID=0, A_RDATA=B_RDATA=0, BUSY=0, RAM_WE=0, RAM_A=0, RAM_D=0.
  - Priority pointer = RR_INIT; clear counter = 0.
- States:
  - IDLE: normal arbitration.
  - CLEAR: clear engine owns the RAM.
  - Reset enters IDLE. When CLR_ON_RESET=1, the FSM moves to CLEAR on the first clock edge after RST drops.
- IDLE arbitration (combinational):
  - If only one REQ is high, that requester is granted.
  - If both are high, the requester named by the priority pointer is granted.
  - On each grant edge the pointer moves to the other requester.
  - At most one GNT is high in any cycle.
  - RAM_A/RAM_D/RAM_WE follow the granted requester. RAM_WE = granted WE.
  - With no grant: RAM_WE=0 and RAM_A holds its last value.
- Write: committed at the CLK edge that ends the grant cycle. No response beyond GNT.
- Read:
  - RAM_O is sampled at the grant-cycle edge into x_RDATA.
  - x_RVALID pulses for exactly one cycle after that edge (1-cycle latency).
  - x_RDATA holds its value until the next read for that requester.
- Back-to-back: a requester holding REQ alone is granted every cycle. Under contention A and B alternate each cycle.
- Read-after-write to the same address on the next cycle returns the new value.
- CLR_REQ in IDLE:
  - Takes precedence over pending REQs that same cycle; no GNT is issued in that cycle.
  - Next state CLEAR; CLR_VAL is latched.
- CLEAR:
  - BUSY=1, RAM_WE=1, RAM_A=counter, RAM_D=latched value.
  - Counter runs 0..255, one location per cycle: exactly 256 cycles.
  - After address 255 is written: counter wraps to 0, FSM returns to IDLE, BUSY=0 in the following cycle.
  - No GNT is issued while BUSY. REQs stay pending and are arbitrated normally once back in IDLE.
  - CLR_REQ during CLEAR is ignored; it neither restarts nor extends the clear.
- RST mid-clear: immediate return to IDLE, BUSY=0, counter=0. RAM contents are partially cleared and treated as undefined.
- RST mid-read: pending RVALID is dropped.

Optional Feature:
- Macro: RAM256_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, A always wins over B. The priority pointer and RR_INIT are unused. B is granted only when A_REQ=0.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then A writes 1 to address 0x3C, then A reads 0x3C -> A_GNT on both request cycles; A_RVALID=1 exactly one cycle after the read grant; A_RDATA=1; B outputs stay 0.
- A and B both hold REQ for 4 cycles, RR_INIT=0, addresses 0x00/0xFF -> grant order A,B,A,B; RAM_A=0x00,0xFF,0x00,0xFF; never both GNT.
- CLR_REQ with CLR_VAL=1, with A_REQ also high on the same cycle -> BUSY high for exactly 256 cycles; RAM_A steps 0x00..0xFF; A_GNT only after BUSY drops; read of 0xA5 returns 1.
- Address 0xFF write of 0, then read on the very next cycle by B -> B_RDATA=0. Then clear with CLR_VAL=0 wraps counter 0xFF->0x00 and FSM returns to IDLE.
- RST asserted at clear cycle 100 -> BUSY=0 and all GNT/RVALID=0 asynchronously; a new CLR_REQ restarts the clear from address 0.
- With RAM256_ARB_FIXED_PRIO_EN defined, both REQ held 3 cycles -> A_GNT all 3 cycles, B_GNT=0; B is granted on the first cycle after A_REQ drops.
